tf_wide2narrow: RTL and testbench
=================================

Name: tf_wide2narrow

Overview:
- Parametrised wide-to-narrow packet width converter, successor to the fixed 512-to-8 transmit converter.
- Buffers wide packet words plus per-packet metadata in internal FIFOs, then serialises each packet MSB-byte-first onto an AXI4-Stream master of configurable width.
- The output side uses a true valid/ready handshake, drives tkeep on the last beat, streams packets back-to-back, and flags overflow.
- Sits between the packet-processing pipeline and the MAC/PHY transmit interface.

Parameters:
IN_W, 512, input data word width in bits; multiple of OUT_W.
OUT_W, 8, output tdata width in bits; one of 8/16/32/64.
DATA_DEPTH, 64, data FIFO depth in words; power of 2.
META_DEPTH, 128, metadata FIFO depth in entries; power of 2.
META_W, 112, metadata width.
LEN_LSB, 96, bit position of the packet byte-length field inside the metadata.
LEN_W, 11, length field width (bytes, 0..2047).
AF_LEVEL, 48, data FIFO fill level at or above which in_alf asserts.

Ports:
clk  in  1  single clock.
srst  in  1  synchronous reset, active-high.
in_data  in  IN_W  packet word; byte 0 at bits [IN_W-1:IN_W-8].
in_wr  in  1  data word write strobe.
in_meta  in  META_W  per-packet metadata; length at [LEN_LSB+LEN_W-1:LEN_LSB].
in_meta_wr  in  1  metadata write strobe.
in_alf  out  1  data FIFO almost full.
ovf  out  1  sticky: a write was attempted to a full FIFO.
m_axis_tdata  out  OUT_W  output bytes, first byte in MSBs.
m_axis_tkeep  out  OUT_W/8  byte enables, MSB-aligned.
m_axis_tvalid  out  1  output valid.
m_axis_tlast  out  1  last beat of packet.
m_axis_tuser  out  1  constant 0.
m_axis_tready  in  1  downstream ready.

Behaviour:
- Reset: srst is synchronous and sampled on the clk edge. All outputs go to 0, both FIFOs are emptied, state goes to IDLE, ovf is cleared. Reset mid-packet abandons the packet with no tlast; tvalid=0 on the next cycle.
- FIFOs: internal, show-ahead.
  - A write to a full FIFO is dropped and sets ovf.
  - Simultaneous read and write when full: the read wins, the write is dropped, and ovf is set.
  - in_alf = data fill count >= AF_LEVEL, registered.
- Definitions: BPW = IN_W/8 bytes per word, BPB = OUT_W/8 bytes per beat, BEATS = BPW/BPB beats per word.
- Output register advance: the register loads when (!tvalid || tready). With tvalid=1 and tready=0, tdata/tkeep/tlast hold stable.
- State IDLE:
  - If meta is non-empty and data is non-empty: latch rem <= len and pop meta.
  - If len == 0: stay in IDLE; no beat is emitted and no data word is popped.
  - Otherwise: lane <= 0, go to SEND.
- State SEND, on each register advance while data is non-empty:
  - Output beat: tdata = head word bytes [lane*BPB .. lane*BPB+BPB-1]; tvalid = 1.
  - Non-final beat (rem > BPB): tkeep = all ones; rem -= BPB; lane++.
  - Word boundary: when lane == BEATS-1, pop the data word and set lane = 0.
  - Final beat (rem <= BPB):
    - tkeep = rem leading ones (MSB side); unused bytes are driven 0; tlast = 1.
    - Pop the data word regardless of lane.
    - If meta and data are non-empty: load the next packet in the same cycle (no idle gap).
    - Otherwise go to IDLE.
- Data underflow: data empty at a register advance inside SEND. Drive tvalid = 0 (bubble) and hold state, lane and rem.
- Latency: meta and data both present in IDLE at cycle N gives the first tvalid at N+2.
- Width rules:
  - rem is LEN_W bits.
  - lane is clog2(BEATS) bits, minimum 1.
  - With BEATS == 1, every beat pops a word.
- Out of scope: packets whose word count is inconsistent with len are the producer's error. The block trusts len.

Optional Feature:
- Macro: TF_W2N_STAT_EN.
- Defined: adds outputs stat_pkt_cnt[31:0] and stat_byte_cnt[31:0].
  - stat_pkt_cnt increments on each accepted beat (tvalid && tready) with tlast.
  - stat_byte_cnt adds popcount(tkeep) on each accepted beat.
  - Both wrap at 2^32 and clear on srst.
- Undefined: neither port nor either counter exists.

Test Plan:
1. IN_W=512, OUT_W=32, one 70-byte packet, tready=1 -> 18 beats; beats 1-17 tkeep=4'hF; beat 18 tkeep=4'hC with tlast; 2 data pops; ovf=0.
2. OUT_W=8, two 64-byte packets queued, tready=1 -> 128 consecutive beats with no tvalid gap; tlast on beats 64 and 128; a 64-byte packet has no partial tkeep.
3. tready toggled 1,0,0,1 mid-packet -> tdata/tkeep stable while tready=0; no byte duplicated or skipped, checked against scoreboard.
4. Meta with len=0, followed by a 5-byte packet -> no output for the first; second emits with OUT_W=32: beat 1 tkeep=4'hF, beat 2 tkeep=4'h8 with tlast.
5. Write 65 words into DATA_DEPTH=64 with no reads -> in_alf=1 once 48 are stored; ovf=1 after the 65th write; stored 64 words intact.
6. srst asserted on beat 3 of a 100-byte packet -> tvalid=0 the next cycle; FIFOs empty; a new packet after reset is emitted correctly from byte 0.

Source files
------------

// File: rtl/tf_wide2narrow_if.sv
// tf_wide2narrow_if: AXI4-Stream link driven by the tf_wide2narrow output side.
// The master modport is the converter, the slave modport is the downstream sink.
interface tf_wide2narrow_if #(
  parameter int OUT_W = 8
);
  logic [OUT_W-1:0]   tdata;
  logic [OUT_W/8-1:0] tkeep;
  logic               tvalid;
  logic               tlast;
  logic               tuser;
  logic               tready;

  modport master (
    output tdata,
    output tkeep,
    output tvalid,
    output tlast,
    output tuser,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tkeep,
    input  tvalid,
    input  tlast,
    input  tuser,
    output tready
  );
endinterface

// File: rtl/tf_wide2narrow.sv
// tf_wide2narrow: parametrised wide-to-narrow packet width converter.
// Packet words (IN_W bits, byte 0 in the MSBs) and per-packet metadata are
// buffered in two show-ahead FIFOs. Each packet is serialised MSB-byte-first
// onto an OUT_W-bit AXI4-Stream master, with MSB-aligned tkeep on the last
// beat and back-to-back packets when the next one is already queued.
// Optional build macro TF_W2N_STAT_EN adds stat_pkt_cnt / stat_byte_cnt.
module tf_wide2narrow #(
  parameter int IN_W       = 512,
  parameter int OUT_W      = 8,
  parameter int DATA_DEPTH = 64,
  parameter int META_DEPTH = 128,
  parameter int META_W     = 112,
  parameter int LEN_LSB    = 96,
  parameter int LEN_W      = 11,
  parameter int AF_LEVEL   = 48
) (
  input  logic              clk,
  input  logic              srst,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_wr,
  input  logic [META_W-1:0] in_meta,
  input  logic              in_meta_wr,
  output logic              in_alf,
  output logic              ovf,
`ifdef TF_W2N_STAT_EN
  output logic [31:0]       stat_pkt_cnt,
  output logic [31:0]       stat_byte_cnt,
`endif
  tf_wide2narrow_if.master  m_axis
);

  localparam int BPW    = IN_W / 8;
  localparam int BPB    = OUT_W / 8;
  localparam int BEATS  = BPW / BPB;
  localparam int LANE_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int DA_W   = $clog2(DATA_DEPTH);
  localparam int MA_W   = $clog2(META_DEPTH);
  localparam int DC_W   = DA_W + 1;
  localparam int MC_W   = MA_W + 1;
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(BEATS - 1);
  localparam logic [LEN_W-1:0]  LEN_BPB   = LEN_W'(BPB);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // data FIFO
  logic [IN_W-1:0]  r_dmem [DATA_DEPTH];
  logic [DA_W-1:0]  r_dwp;
  logic [DA_W-1:0]  r_drp;
  logic [DC_W-1:0]  r_dcnt;
  logic [DC_W-1:0]  w_dcnt_nxt;
  logic             w_dfull;
  logic             w_dempty;
  logic             w_dwr;
  logic             w_dpop;
  logic [IN_W-1:0]  w_dhead;

  // metadata FIFO: only the length field is ever consumed, so only it is stored
  logic [LEN_W-1:0] r_mmem [META_DEPTH];
  logic [MA_W-1:0]  r_mwp;
  logic [MA_W-1:0]  r_mrp;
  logic [MC_W-1:0]  r_mcnt;
  logic [MC_W-1:0]  w_mcnt_nxt;
  logic             w_mfull;
  logic             w_mempty;
  logic             w_mwr;
  logic             w_mpop;
  logic [LEN_W-1:0] w_mhead_len;
  logic             w_meta_unused;

  // flags
  logic             r_ovf;
  logic             r_alf;

  // serialiser state and output register
  state_t           r_state;
  logic [LEN_W-1:0] r_rem;
  logic [LANE_W-1:0] r_lane;
  logic [OUT_W-1:0] r_tdata;
  logic [BPB-1:0]   r_tkeep;
  logic             r_tvalid;
  logic             r_tlast;

  // beat datapath and control decisions
  logic [OUT_W-1:0] w_slice;
  logic [OUT_W-1:0] w_beat_data;
  logic [BPB-1:0]   w_beat_keep;
  logic             w_adv;
  logic             w_final;
  logic             w_start_ok;
  logic             w_len_zero;
  logic             w_chain;

  assign w_dfull     = (r_dcnt == DC_W'(DATA_DEPTH));
  assign w_dempty    = (r_dcnt == DC_W'(0));
  assign w_dwr       = in_wr && !w_dfull;
  assign w_dhead     = r_dmem[r_drp];

  assign w_mfull     = (r_mcnt == MC_W'(META_DEPTH));
  assign w_mempty    = (r_mcnt == MC_W'(0));
  assign w_mwr       = in_meta_wr && !w_mfull;
  assign w_mhead_len = r_mmem[r_mrp];
  // Fields other than the length travel with the packet elsewhere.
  assign w_meta_unused = ^in_meta;

  assign w_adv      = !r_tvalid || m_axis.tready;
  assign w_final    = (r_rem <= LEN_BPB);
  assign w_start_ok = !w_mempty && !w_dempty;
  assign w_len_zero = (w_mhead_len == LEN_W'(0));

  // Next data fill level; a dropped write never counts.
  always_comb begin
    case ({w_dwr, w_dpop})
      2'b10:   w_dcnt_nxt = r_dcnt + DC_W'(1);
      2'b01:   w_dcnt_nxt = r_dcnt - DC_W'(1);
      default: w_dcnt_nxt = r_dcnt;
    endcase
  end

  // Next metadata fill level.
  always_comb begin
    case ({w_mwr, w_mpop})
      2'b10:   w_mcnt_nxt = r_mcnt + MC_W'(1);
      2'b01:   w_mcnt_nxt = r_mcnt - MC_W'(1);
      default: w_mcnt_nxt = r_mcnt;
    endcase
  end

  // Data FIFO storage (contents need no reset, pointers/count gate visibility).
  always_ff @(posedge clk) begin
    if (w_dwr) begin
      r_dmem[r_dwp] <= in_data;
    end
  end

  // Metadata FIFO storage, length field only.
  always_ff @(posedge clk) begin
    if (w_mwr) begin
      r_mmem[r_mwp] <= in_meta[LEN_LSB +: LEN_W];
    end
  end

  // FIFO pointers, fill counts, almost-full and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_dwp  <= DA_W'(0);
      r_drp  <= DA_W'(0);
      r_dcnt <= DC_W'(0);
      r_mwp  <= MA_W'(0);
      r_mrp  <= MA_W'(0);
      r_mcnt <= MC_W'(0);
      r_alf  <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_dwr)  r_dwp <= r_dwp + DA_W'(1);
      if (w_dpop) r_drp <= r_drp + DA_W'(1);
      if (w_mwr)  r_mwp <= r_mwp + MA_W'(1);
      if (w_mpop) r_mrp <= r_mrp + MA_W'(1);
      r_dcnt <= w_dcnt_nxt;
      r_mcnt <= w_mcnt_nxt;
      // Registered from the next count so it always matches the stored level.
      r_alf  <= (w_dcnt_nxt >= DC_W'(AF_LEVEL));
      // A full FIFO drops the write even when a read happens in the same cycle.
      r_ovf  <= r_ovf || (in_wr && w_dfull) || (in_meta_wr && w_mfull);
    end
  end

  // Select the current lane of the head word and blank bytes beyond the packet end.
  always_comb begin
    w_slice = {OUT_W{1'b0}};
    for (int l = 0; l < BEATS; l++) begin
      w_slice = w_slice |
                ({OUT_W{r_lane == LANE_W'(l)}} & w_dhead[IN_W-1-l*OUT_W -: OUT_W]);
    end
    w_beat_keep = {BPB{1'b0}};
    w_beat_data = {OUT_W{1'b0}};
    // rem > BPB on non-final beats, so this yields all ones there.
    for (int b = 0; b < BPB; b++) begin
      if (b < int'(r_rem)) begin
        w_beat_keep[BPB-1-b]         = 1'b1;
        w_beat_data[(BPB-1-b)*8 +: 8] = w_slice[(BPB-1-b)*8 +: 8];
      end else begin
        w_beat_keep[BPB-1-b]         = 1'b0;
        w_beat_data[(BPB-1-b)*8 +: 8] = 8'h00;
      end
    end
  end

  // FIFO pop decisions taken in the same cycle as the serialiser update.
  always_comb begin
    w_dpop  = 1'b0;
    w_mpop  = 1'b0;
    w_chain = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_ok) begin
          w_mpop = 1'b1;
        end else begin
          w_mpop = 1'b0;
        end
      end
      ST_SEND: begin
        if (w_adv && !w_dempty) begin
          if (w_final) begin
            w_dpop = 1'b1;
            // The next packet needs a word beyond the one leaving now.
            if (!w_mempty && (r_dcnt > DC_W'(1))) begin
              w_chain = 1'b1;
              w_mpop  = 1'b1;
            end else begin
              w_chain = 1'b0;
              w_mpop  = 1'b0;
            end
          end else if (r_lane == LANE_LAST) begin
            w_dpop = 1'b1;
          end else begin
            w_dpop = 1'b0;
          end
        end else begin
          w_dpop = 1'b0;
        end
      end
      default: begin
        w_dpop  = 1'b0;
        w_mpop  = 1'b0;
        w_chain = 1'b0;
      end
    endcase
  end

  // Serialiser FSM with the registered AXI4-Stream output stage.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_state  <= ST_IDLE;
      r_rem    <= LEN_W'(0);
      r_lane   <= LANE_W'(0);
      r_tdata  <= {OUT_W{1'b0}};
      r_tkeep  <= {BPB{1'b0}};
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_adv) begin
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
          end
          if (w_start_ok) begin
            r_rem  <= w_mhead_len;
            r_lane <= LANE_W'(0);
            // A zero-length packet is consumed without touching the data FIFO.
            if (!w_len_zero) begin
              r_state <= ST_SEND;
            end
          end
        end
        ST_SEND: begin
          if (w_adv) begin
            if (w_dempty) begin
              // Underflow bubble: hold position until the next word arrives.
              r_tvalid <= 1'b0;
              r_tlast  <= 1'b0;
            end else begin
              r_tvalid <= 1'b1;
              r_tdata  <= w_beat_data;
              r_tkeep  <= w_beat_keep;
              if (w_final) begin
                r_tlast <= 1'b1;
                r_lane  <= LANE_W'(0);
                if (w_chain) begin
                  r_rem <= w_mhead_len;
                  if (w_len_zero) begin
                    r_state <= ST_IDLE;
                  end
                end else begin
                  r_state <= ST_IDLE;
                end
              end else begin
                r_tlast <= 1'b0;
                r_rem   <= r_rem - LEN_BPB;
                if (r_lane == LANE_LAST) begin
                  r_lane <= LANE_W'(0);
                end else begin
                  r_lane <= r_lane + LANE_W'(1);
                end
              end
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef TF_W2N_STAT_EN
  function automatic logic [31:0] keep_popcount(input logic [BPB-1:0] keep);
    logic [31:0] cnt;
    cnt = 32'd0;
    for (int i = 0; i < BPB; i++) begin
      cnt = cnt + 32'(keep[i]);
    end
    return cnt;
  endfunction

  logic [31:0] r_stat_pkt;
  logic [31:0] r_stat_byte;

  // Packet and byte counters over accepted beats; both wrap naturally.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_stat_pkt  <= 32'd0;
      r_stat_byte <= 32'd0;
    end else if (r_tvalid && m_axis.tready) begin
      r_stat_byte <= r_stat_byte + keep_popcount(r_tkeep);
      if (r_tlast) begin
        r_stat_pkt <= r_stat_pkt + 32'd1;
      end
    end
  end

  assign stat_pkt_cnt  = r_stat_pkt;
  assign stat_byte_cnt = r_stat_byte;
`else
  // Statistics counters are not built in this configuration.
`endif

  assign in_alf        = r_alf;
  assign ovf           = r_ovf;
  assign m_axis.tdata  = r_tdata;
  assign m_axis.tkeep  = r_tkeep;
  assign m_axis.tvalid = r_tvalid;
  assign m_axis.tlast  = r_tlast;
  assign m_axis.tuser  = 1'b0;

endmodule

// File: tb/tb_tf_wide2narrow.sv
// tb_tf_wide2narrow: scoreboard bench for tf_wide2narrow.
// Two instances: A with OUT_W=32, B with OUT_W=8 (IN_W=512 for both).
module tb_tf_wide2narrow;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic srst;
  int   cyc = 0;
  int   n_err = 0;
  int   n_checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // instance A (OUT_W = 32)
  logic [511:0] a_data;
  logic         a_wr;
  logic [111:0] a_meta;
  logic         a_mwr;
  logic         a_alf;
  logic         a_ovf;
  logic         a_rdy;
  // instance B (OUT_W = 8)
  logic [511:0] b_data;
  logic         b_wr;
  logic [111:0] b_meta;
  logic         b_mwr;
  logic         b_alf;
  logic         b_ovf;
  logic         b_rdy;
`ifdef TF_W2N_STAT_EN
  logic [31:0]  a_spk, a_sby, b_spk, b_sby;
`endif

  tf_wide2narrow_if #(.OUT_W(32)) a_axis ();
  tf_wide2narrow_if #(.OUT_W(8))  b_axis ();
  assign a_axis.tready = a_rdy;
  assign b_axis.tready = b_rdy;

  tf_wide2narrow #(.OUT_W(32)) dut_a (
    .clk(clk), .srst(srst),
    .in_data(a_data), .in_wr(a_wr), .in_meta(a_meta), .in_meta_wr(a_mwr),
    .in_alf(a_alf), .ovf(a_ovf),
`ifdef TF_W2N_STAT_EN
    .stat_pkt_cnt(a_spk), .stat_byte_cnt(a_sby),
`endif
    .m_axis(a_axis)
  );

  tf_wide2narrow #(.OUT_W(8)) dut_b (
    .clk(clk), .srst(srst),
    .in_data(b_data), .in_wr(b_wr), .in_meta(b_meta), .in_meta_wr(b_mwr),
    .in_alf(b_alf), .ovf(b_ovf),
`ifdef TF_W2N_STAT_EN
    .stat_pkt_cnt(b_spk), .stat_byte_cnt(b_sby),
`endif
    .m_axis(b_axis)
  );

  beat_t a_q[$];
  beat_t b_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pkt_byte(input int seed, input int idx);
    return 8'((seed * 37 + idx * 5 + 1) & 255);
  endfunction

  // Word w of a packet; bytes past len are filled with EE to expose bad masking.
  function automatic logic [511:0] mk_word(input int seed, input int len, input int w);
    logic [511:0] r;
    r = '0;
    for (int k = 0; k < 64; k++) begin
      if (w * 64 + k < len) r[511 - 8 * k -: 8] = pkt_byte(seed, w * 64 + k);
      else                  r[511 - 8 * k -: 8] = 8'hEE;
    end
    return r;
  endfunction

  task automatic push_exp(input int sel, input int seed, input int len);
    int nb;
    int nbeats;
    beat_t e;
    nb = (sel == 0) ? 4 : 1;
    nbeats = (len + nb - 1) / nb;
    for (int j = 0; j < nbeats; j++) begin
      e.data = 32'h0;
      e.keep = 4'h0;
      for (int k = 0; k < nb; k++) begin
        if (j * nb + k < len) begin
          e.keep[nb - 1 - k] = 1'b1;
          e.data[(nb - 1 - k) * 8 +: 8] = pkt_byte(seed, j * nb + k);
        end
      end
      e.last = (j == nbeats - 1);
      if (sel == 0) a_q.push_back(e);
      else          b_q.push_back(e);
    end
  endtask

  task automatic write_word(input int sel, input logic [511:0] d);
    if (sel == 0) begin a_data = d; a_wr = 1'b1; end
    else          begin b_data = d; b_wr = 1'b1; end
    @(posedge clk); #1;
    a_wr = 1'b0;
    b_wr = 1'b0;
  endtask

  task automatic write_meta(input int sel, input int len);
    logic [111:0] m;
    m[31:0]   = $urandom;
    m[63:32]  = $urandom;
    m[95:64]  = $urandom;
    m[111:96] = 16'($urandom);
    m[106:96] = 11'(len);
    if (sel == 0) begin a_meta = m; a_mwr = 1'b1; end
    else          begin b_meta = m; b_mwr = 1'b1; end
    @(posedge clk); #1;
    a_mwr = 1'b0;
    b_mwr = 1'b0;
  endtask

  task automatic send_pkt(input int sel, input int seed, input int len);
    for (int w = 0; w < (len + 63) / 64; w++) write_word(sel, mk_word(seed, len, w));
    push_exp(sel, seed, len);
    write_meta(sel, len);
  endtask

  task automatic wait_drain(input int sel, input int budget, input string name);
    int c;
    c = 0;
    while (((sel == 0) ? a_q.size() : b_q.size()) != 0 && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    n_checks++;
    if (((sel == 0) ? a_q.size() : b_q.size()) != 0) begin
      n_err++;
      $display("FAIL %s: %0d expected beats never arrived", name,
               (sel == 0) ? a_q.size() : b_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
    check({name, "_idle"}, 64'((sel == 0) ? a_axis.tvalid : b_axis.tvalid), 64'd0);
  endtask

  // monitor A: scoreboard, stall stability, per-packet beat/tkeep record
  logic  a_hold_v = 1'b0;
  beat_t a_hold;
  int    a_pkt_beats = 0;
  int    a_last_pkt_beats = 0;
  logic [3:0] a_last_keep = 4'h0;
  int    a_stalls = 0;
  beat_t a_e;

  always @(negedge clk) begin
    if (srst) begin
      a_hold_v = 1'b0;
      a_pkt_beats = 0;
    end else begin
      if (a_hold_v) begin
        check("a_stall_valid", 64'(a_axis.tvalid), 64'd1);
        check("a_stall_hold", 64'({a_axis.tdata, a_axis.tkeep, a_axis.tlast}),
              64'({a_hold.data, a_hold.keep, a_hold.last}));
      end
      if (a_axis.tvalid && a_axis.tready) begin
        n_checks++;
        if (a_q.size() == 0) begin
          n_err++;
          $display("FAIL a_extra_beat: got tdata=%h tkeep=%h tlast=%b, no beat expected",
                   a_axis.tdata, a_axis.tkeep, a_axis.tlast);
        end else begin
          a_e = a_q.pop_front();
          if ({a_axis.tdata, a_axis.tkeep, a_axis.tlast} !== {a_e.data, a_e.keep, a_e.last}) begin
            n_err++;
            $display("FAIL a_beat: got tdata=%h tkeep=%h tlast=%b, expected tdata=%h tkeep=%h tlast=%b",
                     a_axis.tdata, a_axis.tkeep, a_axis.tlast, a_e.data, a_e.keep, a_e.last);
          end
        end
        a_pkt_beats++;
        if (a_axis.tlast) begin
          a_last_keep = a_axis.tkeep;
          a_last_pkt_beats = a_pkt_beats;
          a_pkt_beats = 0;
        end
      end
      if (a_axis.tvalid && !a_axis.tready) a_stalls++;
      a_hold_v = a_axis.tvalid && !a_axis.tready;
      a_hold.data = a_axis.tdata;
      a_hold.keep = a_axis.tkeep;
      a_hold.last = a_axis.tlast;
    end
  end

  // monitor B: scoreboard plus accept-cycle and tlast-position record
  int    b_acc = 0;
  int    b_first_cyc = 0;
  int    b_last_cyc = 0;
  int    b_tl[$];
  beat_t b_e;

  always @(negedge clk) begin
    if (!srst && b_axis.tvalid && b_axis.tready) begin
      n_checks++;
      if (b_q.size() == 0) begin
        n_err++;
        $display("FAIL b_extra_beat: got tdata=%h tlast=%b, no beat expected",
                 b_axis.tdata, b_axis.tlast);
      end else begin
        b_e = b_q.pop_front();
        if ({b_axis.tdata, b_axis.tkeep, b_axis.tlast} !== {b_e.data[7:0], b_e.keep[0], b_e.last}) begin
          n_err++;
          $display("FAIL b_beat: got tdata=%h tkeep=%b tlast=%b, expected tdata=%h tkeep=%b tlast=%b",
                   b_axis.tdata, b_axis.tkeep, b_axis.tlast, b_e.data[7:0], b_e.keep[0], b_e.last);
        end
      end
      if (b_acc == 0) b_first_cyc = cyc;
      b_last_cyc = cyc;
      b_acc++;
      if (b_axis.tlast) b_tl.push_back(b_acc);
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pat[16] = '{1, 1, 1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 1, 1, 0, 1};
    int c;
    srst = 1'b1;
    a_data = '0; a_wr = 1'b0; a_meta = '0; a_mwr = 1'b0; a_rdy = 1'b1;
    b_data = '0; b_wr = 1'b0; b_meta = '0; b_mwr = 1'b0; b_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    // reset state
    check("rst_tvalid", 64'(a_axis.tvalid), 64'd0);
    check("rst_tlast",  64'(a_axis.tlast),  64'd0);
    check("rst_tkeep",  64'(a_axis.tkeep),  64'd0);
    check("rst_tdata",  64'(a_axis.tdata),  64'd0);
    check("rst_tuser",  64'(a_axis.tuser),  64'd0);
    check("rst_alf",    64'(a_alf),         64'd0);
    check("rst_ovf",    64'(a_ovf),         64'd0);
    check("rst_b_tvalid", 64'(b_axis.tvalid), 64'd0);
    srst = 1'b0;
    @(posedge clk); #1;

    // 1: 70-byte packet at 32-bit output, plus first-beat latency
    send_pkt(0, 1, 70);
    @(negedge clk);
    @(negedge clk);
    check("t1_lat_n1", 64'(a_axis.tvalid), 64'd0);
    @(negedge clk);
    check("t1_lat_n2", 64'(a_axis.tvalid), 64'd1);
    @(posedge clk); #1;
    wait_drain(0, 200, "t1_drain");
    check("t1_beats",     64'(a_last_pkt_beats), 64'd18);
    check("t1_last_keep", 64'(a_last_keep),      64'hC);
    check("t1_ovf",       64'(a_ovf),            64'd0);

    // 2: two 64-byte packets at 8-bit output, back-to-back
    write_word(1, mk_word(20, 64, 0));
    write_word(1, mk_word(21, 64, 0));
    push_exp(1, 20, 64);
    write_meta(1, 64);
    push_exp(1, 21, 64);
    write_meta(1, 64);
    wait_drain(1, 400, "t2_drain");
    check("t2_beats",   64'(b_acc), 64'd128);
    check("t2_no_gap",  64'(b_last_cyc - b_first_cyc), 64'd127);
    check("t2_nlast",   64'(b_tl.size()), 64'd2);
    if (b_tl.size() == 2) begin
      check("t2_last1", 64'(b_tl[0]), 64'd64);
      check("t2_last2", 64'(b_tl[1]), 64'd128);
    end

    // 3: tready stalls mid-packet
    send_pkt(0, 3, 40);
    for (int i = 0; i < 16; i++) begin
      a_rdy = pat[i][0];
      @(posedge clk); #1;
    end
    a_rdy = 1'b1;
    wait_drain(0, 200, "t3_drain");
    check("t3_stalls_seen", 64'(a_stalls > 0), 64'd1);

    // 4: zero-length packet followed by a 5-byte packet
    write_word(0, mk_word(4, 5, 0));
    write_meta(0, 0);
    push_exp(0, 4, 5);
    write_meta(0, 5);
    wait_drain(0, 100, "t4_drain");
    check("t4_beats",     64'(a_last_pkt_beats), 64'd2);
    check("t4_last_keep", 64'(a_last_keep),      64'h8);

    // 5: fill the data FIFO past full with no reads
    for (int k = 0; k < 65; k++) begin
      write_word(0, mk_word(100 + k, 64, 0));
      if (k == 46) check("t5_alf_47", 64'(a_alf), 64'd0);
      if (k == 47) check("t5_alf_48", 64'(a_alf), 64'd1);
      if (k == 63) check("t5_ovf_64", 64'(a_ovf), 64'd0);
    end
    check("t5_ovf_65", 64'(a_ovf), 64'd1);
    for (int k = 0; k < 64; k++) begin
      push_exp(0, 100 + k, 64);
      write_meta(0, 64);
    end
    wait_drain(0, 3000, "t5_drain");
    check("t5_ovf_sticky", 64'(a_ovf), 64'd1);

    // 6: reset on beat 3 of a 100-byte packet, then a fresh packet
    send_pkt(0, 7, 100);
    c = 0;
    while (a_q.size() != 23 && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    check("t6_reach_beat3", 64'(a_q.size()), 64'd23);
    srst = 1'b1;
    @(posedge clk); #1;
    check("t6_rst_tvalid", 64'(a_axis.tvalid), 64'd0);
    check("t6_rst_tlast",  64'(a_axis.tlast),  64'd0);
    check("t6_rst_alf",    64'(a_alf),         64'd0);
    check("t6_rst_ovf",    64'(a_ovf),         64'd0);
    srst = 1'b0;
    a_q.delete();
    @(posedge clk); #1;
    check("t6_idle_after", 64'(a_axis.tvalid), 64'd0);
    send_pkt(0, 9, 9);
    wait_drain(0, 100, "t6_drain");
    check("t6_beats",     64'(a_last_pkt_beats), 64'd3);
    check("t6_last_keep", 64'(a_last_keep),      64'h8);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
